// File: rtl/uart_rx_param.sv
// uart_rx_param: UART receiver with a 2-flop input synchronizer and a mid-bit sampling FSM.
// Define UART_RX_PARITY_EN to add a parity bit after the data bits (PARITY_ODD selects odd/even).
module uart_rx_param #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 din,
    output logic                 valid,
    output logic [DATA_BITS-1:0] data,
    output logic                 frame_err,
    output logic                 parity_err
);

    localparam int DIVIDER = CLK_FREQ / BAUD_RATE;
    localparam int CNT_W   = $clog2(DIVIDER);
    localparam int IDX_W   = $clog2(DATA_BITS + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIVIDER - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(DIVIDER / 2 - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_paramCheck
        $error("uart_rx_param: DATA_BITS must be 5..9 and PARITY_ODD 0 or 1");
    end

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        BREAK
    } state_t;

    state_t               r_state;
    state_t               w_nextState;
    logic                 r_sync1;
    logic                 r_sync2;
    logic                 r_sdinPrev;
    logic [1:0]           r_settle;
    logic [CNT_W-1:0]     r_count;
    logic [IDX_W-1:0]     r_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_frameErr;
    logic                 w_sdin;
    logic                 w_fall;
    logic                 w_tick;
    logic                 w_half;
    logic                 w_accept;
    logic                 w_reject;

    assign w_sdin = r_sync2;
    // Falling edges only count once the synchronizer holds real line samples, so a line already low after reset never starts a frame.
    assign w_fall = (r_settle == 2'd3) && r_sdinPrev && !w_sdin;
    assign w_tick = (r_count == CNT_LAST);
    assign w_half = (r_count == CNT_HALF);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_fall) w_nextState = START;
            START:   if (w_half) w_nextState = w_sdin ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
            DATA:    if (w_tick && r_idx == IDX_LAST) w_nextState = PARITY;
            PARITY:  if (w_tick) w_nextState = STOP;
`else
            DATA:    if (w_tick && r_idx == IDX_LAST) w_nextState = STOP;
`endif
            STOP:    if (w_tick) w_nextState = w_sdin ? IDLE : BREAK;
            BREAK:   if (w_sdin) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_comb begin
        w_accept = 1'b0;
        w_reject = 1'b0;
        if (r_state == STOP && w_tick) begin
            w_accept = w_sdin;
            w_reject = !w_sdin;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic r_parBit;
    logic r_parityErr;
    logic w_parityMismatch;

    assign w_parityMismatch = (^{r_shift, r_parBit}) != (PARITY_ODD != 0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_parBit    <= 1'b0;
            r_parityErr <= 1'b0;
        end else begin
            if (r_state == PARITY && w_tick) begin
                r_parBit <= w_sdin;
            end
            r_parityErr <= w_accept && w_parityMismatch;
        end
    end

    assign parity_err = r_parityErr;
`else
    assign parity_err = 1'b0;
`endif

    // The counter restarts on every state change and every bit tick, so it never exceeds DIVIDER-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_sdinPrev <= 1'b1;
            r_settle   <= 2'd0;
            r_count    <= '0;
            r_idx      <= '0;
            r_shift    <= '0;
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_frameErr <= 1'b0;
        end else begin
            r_sync1    <= din;
            r_sync2    <= r_sync1;
            r_sdinPrev <= r_sync2;
            if (r_settle != 2'd3) begin
                r_settle <= r_settle + 2'd1;
            end
            if (r_state != w_nextState || w_tick || r_state == IDLE || r_state == BREAK) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + CNT_W'(1);
            end
            if (r_state != DATA) begin
                r_idx <= '0;
            end else if (w_tick) begin
                r_idx   <= r_idx + IDX_W'(1);
                r_shift <= {w_sdin, r_shift[DATA_BITS-1:1]};
            end
            if (w_accept) begin
                r_data <= r_shift;
            end
            r_valid    <= w_accept;
            r_frameErr <= w_reject;
        end
    end

    assign valid     = r_valid;
    assign data      = r_data;
    assign frame_err = r_frameErr;

endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: drives serial frames into an 8-bit and a 7-bit receiver and checks
// received payloads, error pulses and latency against a behavioural frame model.
module tb_uart_rx_param;

    localparam int CLK_FREQ = 1_600_000;
    localparam int BAUD8    = 100_000;
    localparam int BAUD7    = 115_200;
    localparam int D8       = CLK_FREQ / BAUD8;
    localparam int D7       = CLK_FREQ / BAUD7;
    localparam int PODD     = 0;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic       clk  = 1'b0;
    logic       rst  = 1'b1;
    logic       din8 = 1'b1;
    logic       din7 = 1'b1;
    logic       valid8, frameErr8, parityErr8;
    logic [7:0] data8;
    logic       valid7, frameErr7, parityErr7;
    logic [6:0] data7;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int lastFall8 = 0;

    logic [7:0] rxQ8[$];
    int         rxCyc8[$];
    logic [6:0] rxQ7[$];
    int ferrCnt8 = 0, perrCnt8 = 0, perrAlone8 = 0, perrTotal = 0, ferrCnt7 = 0;

    uart_rx_param #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD8), .DATA_BITS(8), .PARITY_ODD(PODD)) u_dut8 (
        .clk(clk), .rst(rst), .din(din8), .valid(valid8), .data(data8),
        .frame_err(frameErr8), .parity_err(parityErr8)
    );

    uart_rx_param #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD7), .DATA_BITS(7), .PARITY_ODD(PODD)) u_dut7 (
        .clk(clk), .rst(rst), .din(din7), .valid(valid7), .data(data7),
        .frame_err(frameErr7), .parity_err(parityErr7)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Outputs are sampled on the falling edge and collected as events for the tests to compare.
    always @(negedge clk) begin
        if (valid8) begin
            rxQ8.push_back(data8);
            rxCyc8.push_back(cyc);
        end
        if (frameErr8) ferrCnt8++;
        if (parityErr8) begin
            perrCnt8++;
            perrTotal++;
            if (!valid8) perrAlone8++;
        end
        if (valid7) rxQ7.push_back(data7);
        if (frameErr7) ferrCnt7++;
    end

    function automatic logic refParity(input logic [8:0] value, input int nbits);
        logic [8:0] masked;
        masked = value & 9'((1 << nbits) - 1);
        return 1'(($countones(masked) + PODD) % 2);
    endfunction

    task automatic clearMon();
        rxQ8.delete();
        rxCyc8.delete();
        rxQ7.delete();
        ferrCnt8 = 0;
        perrCnt8 = 0;
        perrAlone8 = 0;
        ferrCnt7 = 0;
    endtask

    task automatic driveLine(input int line, input logic b, input int cycles);
        if (line == 0) din8 = b;
        else din7 = b;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic applyStimulus(input int line, input logic [8:0] value, input int nbits, input int div,
                                 input logic parBit, input logic stopBit, input int stopCycles);
        if (line == 0) lastFall8 = cyc;
        driveLine(line, 1'b0, div);
        for (int i = 0; i < nbits; i++) driveLine(line, value[i], div);
        if (PAR_EN) driveLine(line, parBit, div);
        driveLine(line, stopBit, stopCycles);
        driveLine(line, 1'b1, 0);
    endtask

    // A "half-bit" stop is held a few cycles past half a bit to cover the synchronizer delay.
    task automatic sendGood(input int line, input logic [8:0] value);
        int nbits;
        int div;
        nbits = (line == 0) ? 8 : 7;
        div   = (line == 0) ? D8 : D7;
        applyStimulus(line, value, nbits, div, refParity(value, nbits), 1'b1, div / 2 + 4);
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        din8 = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (valid8 !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid8: got %b expected 0", valid8); end
        checks++; if (data8 !== 8'h00) begin errors++; $display("[TB] FAIL reset_data8: got %h expected 00", data8); end
        checks++; if (frameErr8 !== 1'b0) begin errors++; $display("[TB] FAIL reset_ferr8: got %b expected 0", frameErr8); end
        checks++; if (parityErr8 !== 1'b0) begin errors++; $display("[TB] FAIL reset_perr8: got %b expected 0", parityErr8); end
        checks++; if (valid7 !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid7: got %b expected 0", valid7); end
        checks++; if (data7 !== 7'h00) begin errors++; $display("[TB] FAIL reset_data7: got %h expected 00", data7); end
        clearMon();
        rst = 1'b0;
        repeat (3 * D8) @(negedge clk);
        checks++; if (rxQ8.size() !== 0) begin errors++; $display("[TB] FAIL low_line_after_reset: got %0d frames expected 0", rxQ8.size()); end
        checks++; if (ferrCnt8 !== 0) begin errors++; $display("[TB] FAIL low_line_ferr: got %0d expected 0", ferrCnt8); end
        driveLine(0, 1'b1, D8);
    endtask

    task automatic test_back_to_back();
        logic [7:0] expQ[$];
        logic [7:0] got;
        int firstFall;
        int lat;
        int expLat;
        expQ = '{8'h55, 8'hA3, 8'h0F, 8'hF0, 8'h00, 8'hFF};
        for (int i = 0; i < 4; i++) expQ.push_back(8'($urandom_range(0, 255)));
        clearMon();
        firstFall = 0;
        for (int i = 0; i < expQ.size(); i++) begin
            sendGood(0, {1'b0, expQ[i]});
            if (i == 0) firstFall = lastFall8;
        end
        repeat (2 * D8) @(negedge clk);
        checks++; if (rxQ8.size() !== expQ.size()) begin errors++; $display("[TB] FAIL b2b_count: got %0d expected %0d", rxQ8.size(), expQ.size()); end
        for (int i = 0; i < expQ.size(); i++) begin
            got = (i < rxQ8.size()) ? rxQ8[i] : 8'hxx;
            checks++; if (got !== expQ[i]) begin errors++; $display("[TB] FAIL b2b_data[%0d]: got %h expected %h", i, got, expQ[i]); end
        end
        checks++; if (ferrCnt8 !== 0) begin errors++; $display("[TB] FAIL b2b_ferr: got %0d expected 0", ferrCnt8); end
        checks++; if (perrCnt8 !== 0) begin errors++; $display("[TB] FAIL b2b_perr: got %0d expected 0", perrCnt8); end
        checks++; if (data8 !== expQ[expQ.size()-1]) begin errors++; $display("[TB] FAIL b2b_hold: got %h expected %h", data8, expQ[expQ.size()-1]); end
        expLat = D8 / 2 + (8 + 1 + int'(PAR_EN)) * D8 + 4;
        lat = (rxCyc8.size() > 0) ? rxCyc8[0] - firstFall : -1000;
        checks++; if (lat < expLat - 2 || lat > expLat + 2) begin errors++; $display("[TB] FAIL latency: got %0d expected %0d+-2", lat, expLat); end
    endtask

    task automatic test_glitch();
        logic [7:0] got;
        clearMon();
        driveLine(0, 1'b0, D8 / 4);
        driveLine(0, 1'b1, 3 * D8);
        checks++; if (rxQ8.size() !== 0) begin errors++; $display("[TB] FAIL glitch_valid: got %0d frames expected 0", rxQ8.size()); end
        checks++; if (ferrCnt8 !== 0) begin errors++; $display("[TB] FAIL glitch_ferr: got %0d expected 0", ferrCnt8); end
        sendGood(0, 9'h05A);
        repeat (2 * D8) @(negedge clk);
        got = (rxQ8.size() > 0) ? rxQ8[0] : 8'hxx;
        checks++; if (rxQ8.size() !== 1 || got !== 8'h5A) begin errors++; $display("[TB] FAIL glitch_next: got %h (%0d frames) expected 5a", got, rxQ8.size()); end
    endtask

    task automatic test_break();
        logic [7:0] got;
        clearMon();
        applyStimulus(0, 9'h0A5, 8, D8, refParity(9'h0A5, 8), 1'b0, 3 * D8);
        driveLine(0, 1'b1, 2 * D8);
        checks++; if (ferrCnt8 !== 1) begin errors++; $display("[TB] FAIL break_ferr_count: got %0d expected 1", ferrCnt8); end
        checks++; if (rxQ8.size() !== 0) begin errors++; $display("[TB] FAIL break_valid: got %0d frames expected 0", rxQ8.size()); end
        checks++; if (data8 !== 8'h5A) begin errors++; $display("[TB] FAIL break_data_held: got %h expected 5a", data8); end
        sendGood(0, 9'h033);
        repeat (2 * D8) @(negedge clk);
        got = (rxQ8.size() > 0) ? rxQ8[0] : 8'hxx;
        checks++; if (rxQ8.size() !== 1 || got !== 8'h33) begin errors++; $display("[TB] FAIL break_next: got %h (%0d frames) expected 33", got, rxQ8.size()); end
        checks++; if (ferrCnt8 !== 1) begin errors++; $display("[TB] FAIL break_ferr_after: got %0d expected 1", ferrCnt8); end
    endtask

    task automatic test_parity();
`ifdef UART_RX_PARITY_EN
        logic [7:0] vals[$];
        logic       pbits[$];
        logic [7:0] got;
        int         expErr;
        vals  = '{8'h03, 8'h03};
        pbits = '{1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            vals.push_back(8'($urandom_range(0, 255)));
            pbits.push_back(1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < vals.size(); i++) begin
            clearMon();
            applyStimulus(0, {1'b0, vals[i]}, 8, D8, pbits[i], 1'b1, D8 / 2 + 4);
            repeat (2 * D8) @(negedge clk);
            expErr = (pbits[i] != refParity({1'b0, vals[i]}, 8)) ? 1 : 0;
            got = (rxQ8.size() > 0) ? rxQ8[0] : 8'hxx;
            checks++; if (rxQ8.size() !== 1 || got !== vals[i]) begin errors++; $display("[TB] FAIL parity_data[%0d]: got %h (%0d frames) expected %h", i, got, rxQ8.size(), vals[i]); end
            checks++; if (perrCnt8 !== expErr) begin errors++; $display("[TB] FAIL parity_err[%0d]: got %0d pulses expected %0d", i, perrCnt8, expErr); end
            checks++; if (perrAlone8 !== 0) begin errors++; $display("[TB] FAIL parity_with_valid[%0d]: got %0d lone pulses expected 0", i, perrAlone8); end
        end
`else
        checks++; if (perrTotal !== 0) begin errors++; $display("[TB] FAIL parity_tied: got %0d pulses expected 0", perrTotal); end
        checks++; if (parityErr8 !== 1'b0) begin errors++; $display("[TB] FAIL parity_level: got %b expected 0", parityErr8); end
`endif
    endtask

    task automatic test_seven_bit();
        logic [6:0] expQ[$];
        logic [6:0] got;
        expQ = '{7'h7F, 7'h2A};
        for (int i = 0; i < 3; i++) expQ.push_back(7'($urandom_range(0, 127)));
        clearMon();
        for (int i = 0; i < expQ.size(); i++) sendGood(1, {2'b00, expQ[i]});
        repeat (2 * D7) @(negedge clk);
        checks++; if (rxQ7.size() !== expQ.size()) begin errors++; $display("[TB] FAIL seven_count: got %0d expected %0d", rxQ7.size(), expQ.size()); end
        for (int i = 0; i < expQ.size(); i++) begin
            got = (i < rxQ7.size()) ? rxQ7[i] : 7'hxx;
            checks++; if (got !== expQ[i]) begin errors++; $display("[TB] FAIL seven_data[%0d]: got %h expected %h", i, got, expQ[i]); end
        end
        checks++; if (ferrCnt7 !== 0) begin errors++; $display("[TB] FAIL seven_ferr: got %0d expected 0", ferrCnt7); end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] val;
        logic [7:0] got;
        val = 8'hCC;
        clearMon();
        driveLine(0, 1'b0, D8);
        for (int i = 0; i < 4; i++) driveLine(0, val[i], D8);
        driveLine(0, val[4], D8 / 2);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (valid8 !== 1'b0) begin errors++; $display("[TB] FAIL midrst_valid: got %b expected 0", valid8); end
        checks++; if (frameErr8 !== 1'b0) begin errors++; $display("[TB] FAIL midrst_ferr: got %b expected 0", frameErr8); end
        checks++; if (parityErr8 !== 1'b0) begin errors++; $display("[TB] FAIL midrst_perr: got %b expected 0", parityErr8); end
        checks++; if (data8 !== 8'h00) begin errors++; $display("[TB] FAIL midrst_data: got %h expected 00", data8); end
        rst = 1'b0;
        driveLine(0, val[4], D8 / 2 - 1);
        for (int i = 5; i < 8; i++) driveLine(0, val[i], D8);
        driveLine(0, 1'b1, 3 * D8);
        checks++; if (rxQ8.size() !== 0) begin errors++; $display("[TB] FAIL midrst_aborted: got %0d frames expected 0", rxQ8.size()); end
        checks++; if (ferrCnt8 !== 0) begin errors++; $display("[TB] FAIL midrst_no_ferr: got %0d expected 0", ferrCnt8); end
        sendGood(0, {1'b0, val});
        repeat (2 * D8) @(negedge clk);
        got = (rxQ8.size() > 0) ? rxQ8[0] : 8'hxx;
        checks++; if (rxQ8.size() !== 1 || got !== val) begin errors++; $display("[TB] FAIL midrst_next: got %h (%0d frames) expected %h", got, rxQ8.size(), val); end
    endtask

    initial begin
        $display("[TB] uart_rx_param bench start, D8=%0d D7=%0d parity=%0d", D8, D7, PAR_EN);
        test_reset();
        test_back_to_back();
        test_glitch();
        test_break();
        test_parity();
        test_seven_bit();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_param.md
UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 Parameter CLK_FREQ, default 100_000_000: system clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 9600: line bit rate in bits/s. DIVIDER = CLK_FREQ/BAUD_RATE, integer truncation (10416 at defaults).
REQ-003 Parameter DATA_BITS, default 8, legal range 5..9: data bits per frame.
REQ-004 Parameter PARITY_ODD, default 0: 0 selects even parity, 1 selects odd parity. Used only under UART_RX_PARITY_EN.
REQ-005 Port clk, input, 1 bit: single clock; all logic is rising-edge.
REQ-006 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 Port din, input, 1 bit: asynchronous serial line, idle high, LSB first.
REQ-008 Port valid, output, 1 bit: one-cycle pulse when a frame is accepted.
REQ-009 Port data, output, DATA_BITS bits: last accepted frame payload; held stable between valid pulses.
REQ-010 Port frame_err, output, 1 bit: one-cycle pulse when the stop bit samples low.
REQ-011 Port parity_err, output, 1 bit: one-cycle pulse on parity mismatch.

Function
REQ-012 din shall pass through a 2-flop synchronizer; all logic below uses the synchronized value (sdin).
REQ-013 The state machine shall have five states: IDLE, START, DATA, PARITY, STOP, plus BREAK.
REQ-014 IDLE -> START on an sdin 1->0 transition; the bit counter clears to 0 at that point.
REQ-015 START: at count DIVIDER/2-1, sample sdin. If 0 -> DATA with count cleared. If 1, the start is a glitch -> IDLE, with no outputs asserted.
REQ-016 DATA: sample sdin every DIVIDER cycles (count DIVIDER-1), i.e. at mid-bit. Shift LSB first into the shift register; after DATA_BITS samples go to PARITY if UART_RX_PARITY_EN is defined, else to STOP.
REQ-017 PARITY: sample one bit at mid-bit, then go to STOP.
REQ-018 STOP, sdin=1 at mid-bit: load data from the shift register, pulse valid for 1 cycle, go directly to IDLE. The next falling edge is accepted from the following cycle, which permits back-to-back frames with a half-bit stop.
REQ-019 STOP, sdin=0 at mid-bit: pulse frame_err for 1 cycle; valid stays 0 and data is unchanged; go to BREAK.
REQ-020 BREAK: stay until sdin=1, then go to IDLE. This prevents a continuous low line from being read as repeated frames.
REQ-021 Valid latency: the valid rise shall fall within DIVIDER/2 + (DATA_BITS+1+P)*DIVIDER + 4 cycles of the din falling edge, ±2 cycles. P=1 with parity compiled in, else 0.
REQ-022 The bit counter shall be exactly $clog2(DIVIDER) bits wide and never overflow. The data-bit index shall be $clog2(DATA_BITS+1) bits wide.
REQ-023 A din transition during DATA, PARITY or STOP, other than at a sample point, shall have no effect.

Reset
REQ-024 With rst=1 at a clk edge: state=IDLE, counters=0, shift register=0, data=0, valid=0, frame_err=0, parity_err=0, synchronizer flops=1.
REQ-025 Reset mid-frame shall abort the frame with no pulse. After release, the line must see sdin 1->0 before a new frame starts; a line already low does not start one.

Configuration
REQ-026 Macro UART_RX_PARITY_EN, defined: a parity bit follows the data bits. On mismatch with the PARITY_ODD rule, parity_err pulses in the same cycle as valid, and data is still loaded.
REQ-027 Macro UART_RX_PARITY_EN, undefined: no PARITY state and no parity logic; parity_err is tied to 0 and the frame is start + DATA_BITS + stop.

Verification
REQ-028 Defaults, no parity: send 0x55, 0xA3, 0x0F, 0xF0, 0x00, 0xFF with a half-bit stop, back-to-back -> six valid pulses with data equal to each byte in order; frame_err=0.
REQ-029 din low for DIVIDER/4 cycles, then high -> no valid, no frame_err; state returns to IDLE; the following 0x5A frame is received correctly.
REQ-030 Send 0xA5 with the stop bit forced to 0 and din held low for 3*DIVIDER -> exactly one frame_err pulse, no valid, data still equals the previous byte; the next 0x33 frame is received.
REQ-031 UART_RX_PARITY_EN, PARITY_ODD=0: 0x03 with parity 0 -> valid, parity_err=0. 0x03 with parity 1 -> valid plus parity_err in the same cycle, data=0x03.
REQ-032 DATA_BITS=7, BAUD_RATE=115200: send 0x7F then 0x2A -> data=7'h7F then 7'h2A.
REQ-033 Assert rst during bit 4 of a 0xCC frame -> all outputs 0 within 1 cycle, no valid for that frame; the next 0xCC frame is received.
